// File: rtl/pucc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pucc_sequencer
// Brief    : Fetch/decode/execute control stage feeding a combinational ALU;
//            owns the pc, the accumulator and the register file.
// Revision : 1.0 - initial release
// ============================================================================
module pucc_sequencer #(
    parameter int OPCODE_WIDTH    = 4,
    parameter int REGISTER_WIDTH  = 8,
    parameter int OPERAND_WIDTH   = 8,
    parameter int REG_INDEX_WIDTH = 4
) (
    input  logic                                  clock,
    input  logic                                  resetN,
    output logic [OPERAND_WIDTH-1:0]              instrAddr,
    output logic                                  instrReq,
    input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] instrData,
    input  logic                                  instrValid,
    output logic [OPCODE_WIDTH-1:0]               aluOpCode,
    output logic [REGISTER_WIDTH-1:0]             aluAccumulator,
    output logic [REGISTER_WIDTH-1:0]             aluRegisterValue,
    input  logic [REGISTER_WIDTH-1:0]             aluResult,
    output logic [OPERAND_WIDTH-1:0]              pcOut,
    output logic [REGISTER_WIDTH-1:0]             accumulatorOut,
    output logic                                  instrRetired,
    output logic                                  halted
);

    localparam int c_NUM_REGS = 2 ** REG_INDEX_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] c_OP_NOP   = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_LOAD  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_ADD   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_STORE = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_JUMP  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_JUMPZ = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_OR    = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_INC   = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_AND   = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] c_OP_HALT  = OPCODE_WIDTH'(15);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    state_t                               state_q;
    logic [OPERAND_WIDTH-1:0]             pc_q, pc_d;
    logic [REGISTER_WIDTH-1:0]            acc_q, acc_d;
    logic [REGISTER_WIDTH-1:0]            regs_q [c_NUM_REGS];
    logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] instr_q;
    logic [REGISTER_WIDTH-1:0]            regval_q;
    logic [OPCODE_WIDTH-1:0]              alu_op_q;
    logic                                 instr_req_q;
    logic                                 retired_q;
    logic                                 halted_q;

    logic [OPCODE_WIDTH-1:0]              w_opcode;
    logic [OPERAND_WIDTH-1:0]             w_operand;
    logic [REG_INDEX_WIDTH-1:0]           w_reg_idx;
    logic [OPERAND_WIDTH-1:0]             w_pc_inc;

    assign w_opcode  = instr_q[OPCODE_WIDTH+OPERAND_WIDTH-1:OPERAND_WIDTH];
    assign w_operand = instr_q[OPERAND_WIDTH-1:0];
    assign w_reg_idx = instr_q[REG_INDEX_WIDTH-1:0];
    assign w_pc_inc  = pc_q + 1'b1;

    // pc and accumulator only move in EXECUTE; the increment wraps naturally
    always_comb begin
        pc_d  = pc_q;
        acc_d = acc_q;
        if (state_q == S_EXECUTE) begin
            case (w_opcode)
                c_OP_ADD, c_OP_OR, c_OP_INC, c_OP_AND: begin
                    acc_d = aluResult;
                    pc_d  = w_pc_inc;
                end
                c_OP_LOAD: begin
                    acc_d = regval_q;
                    pc_d  = w_pc_inc;
                end
                c_OP_JUMP:  pc_d = w_operand;
                c_OP_JUMPZ: pc_d = (acc_q == '0) ? w_operand : w_pc_inc;
                c_OP_HALT:  pc_d = pc_q;
                default:    pc_d = w_pc_inc;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            acc_q       <= '0;
            for (int i = 0; i < c_NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            instr_q     <= '0;
            regval_q    <= '0;
            alu_op_q    <= c_OP_NOP;
            instr_req_q <= 1'b1;
            retired_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            acc_q     <= acc_d;
            retired_q <= 1'b0;
            alu_op_q  <= c_OP_NOP;
            case (state_q)
                S_FETCH: begin
                    if (instrValid) begin
                        instr_q     <= instrData;
                        instr_req_q <= 1'b0;
                        state_q     <= S_DECODE;
                    end
                end
                // ALU-facing outputs are staged here so they are registered in EXECUTE
                S_DECODE: begin
                    regval_q  <= regs_q[w_reg_idx];
                    alu_op_q  <= w_opcode;
                    retired_q <= 1'b1;
                    state_q   <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    regval_q <= '0;
                    if (w_opcode == c_OP_STORE) begin
                        regs_q[w_reg_idx] <= acc_q;
                    end
                    if (w_opcode == c_OP_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALTED;
                    end else begin
                        instr_req_q <= 1'b1;
                        state_q     <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_HALTED;
                end
            endcase
        end
    end

    assign instrAddr        = pc_q;
    assign instrReq         = instr_req_q;
    assign aluOpCode        = alu_op_q;
    assign aluAccumulator   = acc_q;
    assign aluRegisterValue = regval_q;
    assign pcOut            = pc_q;
    assign accumulatorOut   = acc_q;
    assign instrRetired     = retired_q;
    assign halted           = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_pucc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pucc_sequencer
// Brief    : Directed bench for pucc_sequencer with a program ROM and ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pucc_sequencer;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic [7:0]  instrAddr;
    logic        instrReq;
    logic [11:0] instrData;
    logic        instrValid;
    logic [3:0]  aluOpCode;
    logic [7:0]  aluAccumulator;
    logic [7:0]  aluRegisterValue;
    logic [7:0]  aluResult;
    logic [7:0]  pcOut;
    logic [7:0]  accumulatorOut;
    logic        instrRetired;
    logic        halted;

    logic [11:0] mem [256];
    logic        valid_en = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ret;
    int ret_cyc[$];
    int ret_op[$];
    int ret_rv[$];

    always #5 clock = ~clock;

    assign instrData  = mem[instrAddr];
    assign instrValid = valid_en;

    // Reference ALU; undefined opcodes return a marker value that must never land in acc
    always_comb begin
        aluResult = 8'hA5;
        case (aluOpCode)
            4'd2: aluResult = aluAccumulator + aluRegisterValue;
            4'd6: aluResult = aluAccumulator | aluRegisterValue;
            4'd7: aluResult = aluAccumulator + 8'd1;
            4'd8: aluResult = aluAccumulator & aluRegisterValue;
            default: aluResult = 8'hA5;
        endcase
    end

    pucc_sequencer dut (
        .clock            (clock),
        .resetN           (resetN),
        .instrAddr        (instrAddr),
        .instrReq         (instrReq),
        .instrData        (instrData),
        .instrValid       (instrValid),
        .aluOpCode        (aluOpCode),
        .aluAccumulator   (aluAccumulator),
        .aluRegisterValue (aluRegisterValue),
        .aluResult        (aluResult),
        .pcOut            (pcOut),
        .accumulatorOut   (accumulatorOut),
        .instrRetired     (instrRetired),
        .halted           (halted)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 12'hF00;
    endtask

    task automatic apply_reset(input int n);
        resetN = 1'b0;
        repeat (n) @(posedge clock);
        #1;
        resetN = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Runs until halted (bounded), logging cycle, opcode and register operand per retirement
    task automatic run_prog(input int max_cyc);
        int cyc;
        cyc   = 0;
        n_ret = 0;
        ret_cyc.delete();
        ret_op.delete();
        ret_rv.delete();
        while (halted !== 1'b1 && cyc < max_cyc) begin
            @(posedge clock);
            #1;
            cyc++;
            if (instrRetired === 1'b1) begin
                n_ret++;
                ret_cyc.push_back(cyc);
                ret_op.push_back(int'(aluOpCode));
                ret_rv.push_back(int'(aluRegisterValue));
            end
        end
        check_eq("halt_reached", halted, 1);
    endtask

    initial begin
        clear_mem();

        // T1 reset
        apply_reset(2);
        check_eq("rst_pc", pcOut, 0);
        check_eq("rst_acc", accumulatorOut, 0);
        check_eq("rst_req", instrReq, 1);
        check_eq("rst_addr", instrAddr, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_retired", instrRetired, 0);
        check_eq("rst_aluop", aluOpCode, 0);
        check_eq("rst_alurv", aluRegisterValue, 0);

        // T2 INC,INC,INC,STORE r1,ADD r1,HALT
        clear_mem();
        mem[0] = 12'h700; mem[1] = 12'h700; mem[2] = 12'h700;
        mem[3] = 12'h301; mem[4] = 12'h201; mem[5] = 12'hF00;
        apply_reset(2);
        run_prog(60);
        check_eq("t2_nret", n_ret, 6);
        check_eq("t2_first_lat", qget(ret_cyc, 0), 2);
        for (int k = 1; k < 6; k++)
            check_eq($sformatf("t2_gap%0d", k), qget(ret_cyc, k) - qget(ret_cyc, k - 1), 3);
        check_eq("t2_add_op", qget(ret_op, 4), 2);
        check_eq("t2_add_r1", qget(ret_rv, 4), 3);
        check_eq("t2_acc", accumulatorOut, 6);
        check_eq("t2_pc", pcOut, 5);
        check_eq("t2_req", instrReq, 0);
        step(4);
        check_eq("t2_hold_pc", pcOut, 5);
        check_eq("t2_hold_halt", halted, 1);
        check_eq("t2_hold_ret", instrRetired, 0);

        // T3 wait states
        clear_mem();
        mem[0] = 12'h700; mem[1] = 12'hF00;
        valid_en = 1'b0;
        apply_reset(2);
        for (int k = 0; k < 4; k++) begin
            step(1);
            check_eq($sformatf("t3_req%0d", k), instrReq, 1);
            check_eq($sformatf("t3_pc%0d", k), pcOut, 0);
        end
        check_eq("t3_noret", instrRetired, 0);
        valid_en = 1'b1;
        run_prog(30);
        check_eq("t3_lat", qget(ret_cyc, 0), 2);
        check_eq("t3_acc", accumulatorOut, 1);
        check_eq("t3_pc", pcOut, 1);

        // T4 branches
        clear_mem();
        mem[0] = 12'h540;
        apply_reset(2);
        run_prog(30);
        check_eq("t4_jz_taken", pcOut, 8'h40);

        clear_mem();
        mem[0] = 12'h700; mem[1] = 12'h540; mem[2] = 12'hF00;
        apply_reset(2);
        run_prog(30);
        check_eq("t4_jz_not", pcOut, 2);
        check_eq("t4_jz_acc", accumulatorOut, 1);

        clear_mem();
        mem[0] = 12'h4FF; mem[255] = 12'h000;
        apply_reset(2);
        step(3);
        check_eq("t4_jmp_pc", pcOut, 8'hFF);
        check_eq("t4_jmp_addr", instrAddr, 8'hFF);
        step(3);
        check_eq("t4_wrap_pc", pcOut, 8'h00);

        // T5 undefined opcode 9
        clear_mem();
        for (int i = 0; i < 5; i++) mem[i] = 12'h700;
        mem[5] = 12'h900; mem[6] = 12'hF00;
        apply_reset(2);
        run_prog(60);
        check_eq("t5_nret", n_ret, 7);
        check_eq("t5_undef_op", qget(ret_op, 5), 9);
        check_eq("t5_acc", accumulatorOut, 5);
        check_eq("t5_pc", pcOut, 6);

        // T6 reset during EXECUTE of STORE r2
        clear_mem();
        mem[0] = 12'h700; mem[1] = 12'h302; mem[2] = 12'hF00;
        apply_reset(2);
        step(5);
        check_eq("t6_in_exec", aluOpCode, 3);
        resetN = 1'b0;
        step(1);
        check_eq("t6_pc", pcOut, 0);
        check_eq("t6_acc", accumulatorOut, 0);
        check_eq("t6_req", instrReq, 1);
        check_eq("t6_ret", instrRetired, 0);
        resetN = 1'b1;
        mem[0] = 12'h102; mem[1] = 12'hF00;
        run_prog(30);
        check_eq("t6_r2_val", qget(ret_rv, 0), 0);
        check_eq("t6_acc_after", accumulatorOut, 0);

        // STORE then LOAD of the same register
        clear_mem();
        mem[0] = 12'h700; mem[1] = 12'h303; mem[2] = 12'h700;
        mem[3] = 12'h700; mem[4] = 12'h103; mem[5] = 12'hF00;
        apply_reset(2);
        run_prog(60);
        check_eq("t7_load_rv", qget(ret_rv, 4), 1);
        check_eq("t7_acc", accumulatorOut, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
